// File: rtl/note_seq_pkg.sv
// Shared definitions for the note sequencer: state encoding, base tone table
// and the key portion of a stored entry {dur, octave, note}.
package note_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RECORD = 2'd1,
        ST_PLAY   = 2'd2
    } seq_state_t;

    localparam logic [3:0] REST_NOTE = 4'd12;
    localparam int         BASE_W    = 9;

    // Index 0 = C ... index 11 = B, in Hz at octave shift 0
    localparam logic [11:0][BASE_W-1:0] BASE_FREQ = {
        9'd494, 9'd466, 9'd440, 9'd415, 9'd392, 9'd370,
        9'd349, 9'd330, 9'd311, 9'd294, 9'd277, 9'd262
    };

    typedef struct packed {
        logic [1:0] octave;
        logic [3:0] note;
    } note_key_t;

    localparam int KEY_W = $bits(note_key_t);

endpackage

// File: rtl/note_sequencer_if.sv
// Control/status bundle between the keyboard decoder side and note_sequencer.
interface note_sequencer_if #(
    parameter int DEPTH  = 16,
    parameter int FREQ_W = 32
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = $clog2(DEPTH);

    logic              note_valid;
    logic [3:0]        note;
    logic [1:0]        octave;
    logic              rec_en;
    logic              play_start;
    logic              play_stop;
    logic              loop_en;
    logic              clear;
    logic [FREQ_W-1:0] freq_out;
    logic [CNT_W-1:0]  count;
    logic [IDX_W-1:0]  play_idx;
    logic              recording;
    logic              playing;
    logic              full;

    modport master (
        output note_valid, note, octave, rec_en, play_start, play_stop, loop_en, clear,
        input  freq_out, count, play_idx, recording, playing, full
    );

    modport slave (
        input  note_valid, note, octave, rec_en, play_start, play_stop, loop_en, clear,
        output freq_out, count, play_idx, recording, playing, full
    );
endinterface

// File: rtl/note_freq_lut.sv
// Combinational note/octave to tone frequency; rest notes map to silence.
module note_freq_lut
    import note_seq_pkg::*;
#(
    parameter int FREQ_W = 32
) (
    input  note_key_t         key,
    output logic [FREQ_W-1:0] freq
);

    // Octave shift doubles the base frequency per step
    always_comb begin
        if (key.note >= REST_NOTE) begin
            freq = '0;
        end else begin
            freq = FREQ_W'(BASE_FREQ[key.note]) << key.octave;
        end
    end

endmodule

// File: rtl/note_sequencer.sv
// Record/playback note sequencer: captures keyboard notes with tick-resolution
// durations into a small memory and replays them once or looped.
module note_sequencer
    import note_seq_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter int DUR_W    = 8,
    parameter int TICK_DIV = 500000,
    parameter int FREQ_W   = 32
) (
    input logic             CLOCK_50,
    input logic             reset,
    note_sequencer_if.slave bus
);
    localparam int CNT_W   = $clog2(DEPTH + 1);
    localparam int IDX_W   = $clog2(DEPTH);
    localparam int PRESC_W = $clog2(TICK_DIV);
    localparam int ENTRY_W = DUR_W + KEY_W;

    seq_state_t         state_r, state_next_s;
    logic [CNT_W-1:0]   count_r, count_next_s;
    logic [IDX_W-1:0]   idx_r, idx_next_s;
    logic [FREQ_W-1:0]  freq_r, freq_next_s;
    logic [PRESC_W-1:0] presc_r, presc_next_s;
    logic [DUR_W-1:0]   dur_cnt_r, dur_cnt_next_s;
    logic               pend_valid_r, pend_valid_next_s;
    note_key_t          pend_key_r, pend_key_next_s;
    logic [DUR_W-1:0]   pend_dur_r, pend_dur_next_s;
    logic               recording_r, playing_r, full_r;
    logic [ENTRY_W-1:0] mem_r [DEPTH];

    logic               tick_s, last_s, no_room_s, wr_en_s;
    logic [IDX_W-1:0]   rd_addr_s;
    logic [ENTRY_W-1:0] rd_entry_s;
    logic [DUR_W-1:0]   rd_dur_s, commit_dur_s;
    note_key_t          rd_key_s, in_key_s, lut_key_s;
    logic [FREQ_W-1:0]  lut_freq_s;

    assign tick_s       = (presc_r == PRESC_W'(TICK_DIV - 1));
    assign last_s       = ((CNT_W'(idx_r) + CNT_W'(1)) == count_r);
    // Accepting another note while one is pending must leave room for both
    assign no_room_s    = pend_valid_r && (count_r >= CNT_W'(DEPTH - 1));
    assign commit_dur_s = (pend_dur_r == '0) ? DUR_W'(1) : pend_dur_r;
    assign rd_entry_s   = mem_r[rd_addr_s];
    assign rd_dur_s     = rd_entry_s[ENTRY_W-1:KEY_W];
    assign rd_key_s     = note_key_t'(rd_entry_s[KEY_W-1:0]);
    assign in_key_s     = '{octave: bus.octave, note: bus.note};

    // Read address tracks the entry that would be loaded on the next advance
    always_comb begin
        if ((state_r == ST_PLAY) && !last_s) begin
            rd_addr_s = idx_r + IDX_W'(1);
        end else begin
            rd_addr_s = '0;
        end
    end

    // Recording looks up the live key, otherwise the entry being loaded
    always_comb begin
        if (state_r == ST_RECORD) begin
            lut_key_s = in_key_s;
        end else begin
            lut_key_s = rd_key_s;
        end
    end

    note_freq_lut #(.FREQ_W(FREQ_W)) u_lut (
        .key  (lut_key_s),
        .freq (lut_freq_s)
    );

    // Next-state, datapath and memory-write decisions for the three modes
    always_comb begin
        state_next_s      = state_r;
        count_next_s      = count_r;
        idx_next_s        = idx_r;
        freq_next_s       = freq_r;
        dur_cnt_next_s    = dur_cnt_r;
        pend_valid_next_s = pend_valid_r;
        pend_key_next_s   = pend_key_r;
        pend_dur_next_s   = pend_dur_r;
        presc_next_s      = tick_s ? '0 : presc_r + PRESC_W'(1);
        wr_en_s           = 1'b0;
        case (state_r)
            ST_IDLE: begin
                freq_next_s = '0;
                idx_next_s  = '0;
                if (bus.play_stop) begin
                    state_next_s = ST_IDLE;
                end else if (bus.clear) begin
                    count_next_s = '0;
                end else if (bus.play_start) begin
                    if (count_r != '0) begin
                        state_next_s   = ST_PLAY;
                        dur_cnt_next_s = rd_dur_s;
                        freq_next_s    = lut_freq_s;
                        presc_next_s   = '0;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end else if (bus.rec_en) begin
                    state_next_s      = ST_RECORD;
                    count_next_s      = '0;
                    pend_valid_next_s = 1'b0;
                    presc_next_s      = '0;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RECORD: begin
                if (!bus.rec_en) begin
                    if (pend_valid_r && (count_r < CNT_W'(DEPTH))) begin
                        wr_en_s      = 1'b1;
                        count_next_s = count_r + CNT_W'(1);
                    end else begin
                        wr_en_s = 1'b0;
                    end
                    pend_valid_next_s = 1'b0;
                    freq_next_s       = '0;
                    state_next_s      = ST_IDLE;
                end else if (bus.note_valid && !no_room_s) begin
                    if (pend_valid_r) begin
                        wr_en_s      = 1'b1;
                        count_next_s = count_r + CNT_W'(1);
                    end else begin
                        wr_en_s = 1'b0;
                    end
                    pend_valid_next_s = 1'b1;
                    pend_key_next_s   = in_key_s;
                    pend_dur_next_s   = '0;
                    freq_next_s       = lut_freq_s;
                    presc_next_s      = '0;
                end else if (tick_s && pend_valid_r && (pend_dur_r != '1)) begin
                    pend_dur_next_s = pend_dur_r + DUR_W'(1);
                end else begin
                    pend_dur_next_s = pend_dur_r;
                end
            end
            ST_PLAY: begin
                if (bus.play_stop) begin
                    state_next_s = ST_IDLE;
                    freq_next_s  = '0;
                    idx_next_s   = '0;
                end else if (tick_s) begin
                    if (dur_cnt_r != DUR_W'(1)) begin
                        dur_cnt_next_s = dur_cnt_r - DUR_W'(1);
                    end else if (!last_s || bus.loop_en) begin
                        idx_next_s     = rd_addr_s;
                        dur_cnt_next_s = rd_dur_s;
                        freq_next_s    = lut_freq_s;
                    end else begin
                        state_next_s = ST_IDLE;
                        freq_next_s  = '0;
                        idx_next_s   = '0;
                    end
                end else begin
                    dur_cnt_next_s = dur_cnt_r;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
                freq_next_s  = '0;
                idx_next_s   = '0;
            end
        endcase
    end

    // State and datapath registers; status flags are registered from next values
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            count_r      <= '0;
            idx_r        <= '0;
            freq_r       <= '0;
            presc_r      <= '0;
            dur_cnt_r    <= '0;
            pend_valid_r <= 1'b0;
            pend_key_r   <= '0;
            pend_dur_r   <= '0;
            recording_r  <= 1'b0;
            playing_r    <= 1'b0;
            full_r       <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            count_r      <= count_next_s;
            idx_r        <= idx_next_s;
            freq_r       <= freq_next_s;
            presc_r      <= presc_next_s;
            dur_cnt_r    <= dur_cnt_next_s;
            pend_valid_r <= pend_valid_next_s;
            pend_key_r   <= pend_key_next_s;
            pend_dur_r   <= pend_dur_next_s;
            recording_r  <= (state_next_s == ST_RECORD);
            playing_r    <= (state_next_s == ST_PLAY);
            full_r       <= (count_next_s == CNT_W'(DEPTH));
        end
    end

    // Entry memory: committed notes land at the current count
    always_ff @(posedge CLOCK_50) begin
        if (wr_en_s) begin
            mem_r[count_r[IDX_W-1:0]] <= {commit_dur_s, pend_key_r};
        end
    end

    assign bus.freq_out  = freq_r;
    assign bus.count     = count_r;
    assign bus.play_idx  = idx_r;
    assign bus.recording = recording_r;
    assign bus.playing   = playing_r;
    assign bus.full      = full_r;

endmodule

// File: tb/tb_note_sequencer.sv
// Randomised and directed bench for note_sequencer with a timeline-based
// reference model (durations and playback position derived from cycle counts).
module tb_note_sequencer;
    localparam int T  = 4;
    localparam int D  = 4;
    localparam int DW = 4;
    localparam int FW = 32;
    localparam int DMAX = (1 << DW) - 1;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;
    bit   chk_en = 1'b0;

    note_sequencer_if #(.DEPTH(D), .FREQ_W(FW)) bus ();

    note_sequencer #(.DEPTH(D), .DUR_W(DW), .TICK_DIV(T), .FREQ_W(FW)) dut (
        .CLOCK_50 (clk),
        .reset    (reset),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    int base_hz [12] = '{262, 277, 294, 311, 330, 349, 370, 392, 415, 440, 466, 494};

    // Reference model state (mode 0 idle, 1 record, 2 play)
    int cyc = 0;
    int mode = 0;
    int m_note[$];
    int m_oct[$];
    int m_dur[$];
    bit pend = 1'b0;
    int pend_note, pend_oct, pend_start;
    int play_base;
    int exp_freq = 0;
    int exp_idx = 0;

    function automatic int note_hz(int n, int o);
        if (n >= 12) return 0;
        return base_hz[n] * (1 << o);
    endfunction

    // Ticks seen strictly between the note's start cycle and the closing event
    function automatic int dur_of(int start, int now);
        int d;
        d = (now - start - 1) / T;
        if (d < 1) d = 1;
        if (d > DMAX) d = DMAX;
        return d;
    endfunction

    task automatic commit(int now);
        if (m_dur.size() < D) begin
            m_note.push_back(pend_note);
            m_oct.push_back(pend_oct);
            m_dur.push_back(dur_of(pend_start, now));
        end
    endtask

    task automatic empty_mem();
        m_note.delete();
        m_oct.delete();
        m_dur.delete();
    endtask

    task automatic model_step();
        int el, total, acc;
        if (reset) begin
            mode = 0; pend = 1'b0; exp_freq = 0; exp_idx = 0;
            empty_mem();
        end else begin
            case (mode)
                0: begin
                    exp_freq = 0; exp_idx = 0;
                    if (bus.play_stop) begin
                        mode = 0;
                    end else if (bus.clear) begin
                        empty_mem();
                    end else if (bus.play_start) begin
                        if (m_dur.size() > 0) begin
                            mode = 2; play_base = cyc;
                        end
                    end else if (bus.rec_en) begin
                        mode = 1; pend = 1'b0;
                        empty_mem();
                    end
                end
                1: begin
                    if (!bus.rec_en) begin
                        if (pend) commit(cyc);
                        pend = 1'b0; mode = 0; exp_freq = 0;
                    end else if (bus.note_valid && (m_dur.size() + int'(pend) + 1 <= D)) begin
                        if (pend) commit(cyc);
                        pend = 1'b1; pend_note = bus.note; pend_oct = bus.octave;
                        pend_start = cyc;
                        exp_freq = note_hz(pend_note, pend_oct);
                    end
                end
                default: begin
                    if (bus.play_stop) begin
                        mode = 0; exp_freq = 0; exp_idx = 0;
                    end else begin
                        total = 0;
                        foreach (m_dur[i]) total += m_dur[i] * T;
                        if (cyc - play_base == total) begin
                            if (bus.loop_en) play_base = cyc;
                            else begin mode = 0; exp_freq = 0; exp_idx = 0; end
                        end
                    end
                end
            endcase
            if (mode == 2) begin
                el = cyc - play_base; acc = 0;
                for (int i = 0; i < m_dur.size(); i++) begin
                    if (el >= acc && el < acc + m_dur[i] * T) begin
                        exp_idx = i; exp_freq = note_hz(m_note[i], m_oct[i]);
                    end
                    acc += m_dur[i] * T;
                end
            end
        end
        cyc++;
    endtask

    task automatic check(string nm, longint act, longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Model advances on the same edge the DUT samples its inputs
    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Every-cycle comparison of all outputs against the model
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            check("freq_out", bus.freq_out, exp_freq);
            check("count", bus.count, m_dur.size());
            check("play_idx", bus.play_idx, exp_idx);
            check("recording", bus.recording, mode == 1);
            check("playing", bus.playing, mode == 2);
            check("full", bus.full, m_dur.size() == D);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic wait_cyc(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(int n, int o);
        bus.note = 4'(n); bus.octave = 2'(o); bus.note_valid = 1'b1;
        @(negedge clk);
        bus.note_valid = 1'b0;
    endtask

    task automatic pulse_start();
        bus.play_start = 1'b1; @(negedge clk); bus.play_start = 1'b0;
    endtask

    task automatic pulse_stop();
        bus.play_stop = 1'b1; @(negedge clk); bus.play_stop = 1'b0;
    endtask

    task automatic pulse_clear();
        bus.clear = 1'b1; @(negedge clk); bus.clear = 1'b0;
    endtask

    task automatic wait_play_done();
        for (int i = 0; i < 400 && bus.playing; i++) @(negedge clk);
        #1;
        check("play_done", bus.playing, 0);
    endtask

    initial begin
        reset = 1'b1;
        bus.note_valid = 1'b0; bus.note = 4'd0; bus.octave = 2'd0;
        bus.rec_en = 1'b0; bus.play_start = 1'b0; bus.play_stop = 1'b0;
        bus.loop_en = 1'b0; bus.clear = 1'b0;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        #1;
        check("rst_freq", bus.freq_out, 0);
        check("rst_count", bus.count, 0);
        check("rst_playing", bus.playing, 0);
        check("rst_recording", bus.recording, 0);
        check("rst_full", bus.full, 0);
        reset = 1'b0;

        // Record A (3 ticks) then C oct1 (2 ticks), play once
        @(negedge clk); bus.rec_en = 1'b1;
        @(negedge clk);
        press(9, 0); wait_cyc(12); press(0, 1); wait_cyc(8);
        bus.rec_en = 1'b0; wait_cyc(2);
        #1; check("rec2_count", bus.count, 2);
        pulse_start();
        #1; check("play_a_first", bus.freq_out, 440);
        wait_cyc(11); #1; check("play_a_last", bus.freq_out, 440);
        wait_cyc(1);  #1; check("play_c_first", bus.freq_out, 524);
        wait_cyc(7);  #1; check("play_c_last", bus.freq_out, 524);
        wait_cyc(1);  #1; check("play_end_freq", bus.freq_out, 0);
        check("play_end_playing", bus.playing, 0);

        // Looped playback then stop
        wait_cyc(2); bus.loop_en = 1'b1;
        pulse_start(); wait_cyc(20);
        #1; check("loop_wrap", bus.freq_out, 440);
        wait_cyc(13); pulse_stop();
        #1; check("stop_freq", bus.freq_out, 0);
        check("stop_playing", bus.playing, 0);
        bus.loop_en = 1'b0; wait_cyc(2);

        // Five notes into four entries
        bus.rec_en = 1'b1; wait_cyc(1);
        for (int i = 0; i < 5; i++) begin
            press(i * 2, 1); wait_cyc(5);
        end
        bus.rec_en = 1'b0; wait_cyc(2);
        #1; check("full_count", bus.count, 4);
        check("full_flag", bus.full, 1);
        pulse_start(); wait_cyc(40);
        #1; check("full_played", bus.playing, 0);

        // Saturated duration followed by a rest
        bus.rec_en = 1'b1; wait_cyc(1);
        press(5, 2); wait_cyc(85); press(13, 0); wait_cyc(10);
        bus.rec_en = 1'b0; wait_cyc(2);
        pulse_start();
        #1; check("sat_first", bus.freq_out, 1396);
        wait_cyc(59); #1; check("sat_last", bus.freq_out, 1396);
        wait_cyc(1);  #1; check("rest_freq", bus.freq_out, 0);
        check("rest_playing", bus.playing, 1);
        wait_cyc(10); #1; check("rest_done", bus.playing, 0);

        // Edge cases
        pulse_clear(); #1; check("clear_idle", bus.count, 0);
        pulse_start(); #1; check("start_empty", bus.playing, 0);
        bus.rec_en = 1'b1; wait_cyc(1);
        press(4, 0); wait_cyc(6); press(7, 3); wait_cyc(6);
        bus.rec_en = 1'b0; wait_cyc(2);
        bus.play_start = 1'b1; bus.play_stop = 1'b1;
        @(negedge clk);
        bus.play_start = 1'b0; bus.play_stop = 1'b0;
        #1; check("start_stop", bus.playing, 0);
        pulse_start(); wait_cyc(2); pulse_clear();
        #1; check("clear_in_play", bus.count, 2);
        check("clear_in_play_run", bus.playing, 1);
        wait_cyc(2); reset = 1'b1; @(negedge clk); reset = 1'b0;
        #1; check("reset_play_count", bus.count, 0);
        check("reset_play_playing", bus.playing, 0);
        wait_cyc(2);

        // Randomised sessions
        for (int it = 0; it < 20; it++) begin
            bus.rec_en = 1'b1; wait_cyc(1);
            for (int j = 0; j < int'($urandom_range(1, 6)); j++) begin
                press($urandom_range(0, 15), $urandom_range(0, 3));
                wait_cyc($urandom_range(0, 30));
            end
            bus.rec_en = 1'b0; wait_cyc(2);
            if ($urandom_range(0, 3) == 0) pulse_clear();
            bus.loop_en = 1'($urandom_range(0, 1));
            pulse_start();
            if (bus.loop_en || ($urandom_range(0, 2) == 0)) begin
                wait_cyc($urandom_range(0, 120));
                pulse_stop();
            end
            wait_play_done();
            bus.loop_en = 1'b0; wait_cyc(2);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
